pci_arbiter: RTL and testbench
==============================

# pci_arbiter

Central PCI bus arbiter: samples active-low REQ_ lines from up to N bus masters, issues one active-low GNT_ at a time with rotating (round-robin) priority, and tracks bus ownership from FRAME_/IRDY_. Sits beside the PCI bus protocol checkers at the bus top level and drives the GNT_ pins; the checkers observe the resulting transactions.

## Interface
- N_MASTERS, 4: number of requesting masters (2..8).
- PARK_MASTER, 0: index granted when bus is parked (used only with parking compiled in).
- TIMEOUT_CYCLES, 16: idle-bus cycles a granted master has to assert FRAME_ before the grant is revoked.
- clk  input  1  bus clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- REQ_  input  N_MASTERS  per-master request, active low.
- FRAME_  input  1  PCI FRAME_, active low.
- IRDY_  input  1  PCI IRDY_, active low.
- GNT_  output  N_MASTERS  per-master grant, active low, registered, at most one bit low.
- owner  output  $clog2(N_MASTERS)  index of the granted or transacting master.
- owner_vld  output  1  owner is meaningful.
- timeout  output  1  one-cycle pulse when a grant is revoked for lack of FRAME_.

## Operation
- Bus idle = FRAME_ high and IRDY_ high, sampled at posedge. X/Z on FRAME_/IRDY_ is treated as not-idle.
- States: IDLE, GRANT, BUSY, DEAD (plus PARK with parking enabled).
- IDLE: all GNT_ high. Any REQ_ low -> pick winner, GRANT; GNT_[winner] low next cycle.
- Winner: first REQ_ low searching upward from last_owner+1, wrapping modulo N_MASTERS.
- GRANT: GNT_[owner] low; timer counts cycles with bus idle. FRAME_ low -> BUSY, timer cleared, last_owner <= owner. REQ_[owner] high before FRAME_ -> DEAD. Timer reaches TIMEOUT_CYCLES -> timeout pulse, last_owner <= owner (offender drops to lowest priority), DEAD.
- BUSY: transaction in progress. GNT_[owner] held low while no other REQ_ low; any other REQ_ low -> GNT_[owner] driven high (preemption request), owner/owner_vld unchanged. Bus idle -> DEAD.
- DEAD: all GNT_ high for exactly one cycle, owner_vld 0 -> IDLE (or PARK). Guarantees one dead cycle between any two grants.
- Never two GNT_ bits low in the same cycle; never a GNT_ low on a different master in the cycle after another GNT_ was low.
- Reset values: GNT_ all ones, owner 0, owner_vld 0, timeout 0, state IDLE, timer 0, last_owner N_MASTERS-1 (master 0 wins first tie).
- Reset asserted mid-operation: all of the above restored at the next posedge regardless of state or bus activity.

## Timing
- REQ_ low sampled at edge k (bus idle, state IDLE) -> GNT_ low visible after edge k+1; owner_vld high same cycle.
- Grant switch latency: previous GNT_ high at edge j, next GNT_ low at edge j+2 at earliest.
- timeout pulses in the cycle DEAD is entered, exactly one cycle wide.
- Timer is 5 bits, saturates; counts only in GRANT with bus idle.

## Configuration
- PCI_ARB_PARK_EN defined: from IDLE with no REQ_ low, enter PARK; GNT_[PARK_MASTER] low, owner=PARK_MASTER, owner_vld 1, no timeout. FRAME_ low in PARK -> BUSY (parked master owns bus). Any REQ_ low other than PARK_MASTER -> DEAD then arbitrate; REQ_[PARK_MASTER] low -> GRANT directly, no dead cycle.
- Not defined: no PARK state; with no requests all GNT_ stay high.

## Structure
- Package pci_arb_pkg: state enum (IDLE, GRANT, BUSY, DEAD, PARK), default TIMEOUT_CYCLES constant.
- Sub-module pci_arb_rr_pick: combinational round-robin picker (REQ_ vector, last_owner -> winner index, any_req).
- FSM, timer and GNT_ register in pci_arbiter.

## Test plan
- Reset, then REQ_=4'b1110 -> GNT_=4'b1110 after 2 edges, owner=0, owner_vld=1; FRAME_ low then FRAME_/IRDY_ high -> one cycle GNT_=4'b1111, then back to IDLE.
- REQ_=4'b0000 held, each master runs a 3-cycle transaction -> grants in order 0,1,2,3,0 with one all-high GNT_ cycle between each.
- Master 1 granted, never asserts FRAME_ -> after 16 idle cycles timeout=1 for one cycle, GNT_ all high, next grant to master 2 with REQ_=4'b0000.
- Master 0 in BUSY, master 2 asserts REQ_ -> GNT_[0] high next cycle while FRAME_ low, owner stays 0; after bus idle, dead cycle, GNT_=4'b1011.
- reset pulsed during BUSY -> next edge GNT_=4'b1111, owner_vld=0, timeout=0.
- With PCI_ARB_PARK_EN, PARK_MASTER=3, no requests -> GNT_=4'b0111; REQ_[1] low -> one dead cycle then GNT_=4'b1101.

Source files
------------

// File: rtl/pci_arb_pkg.sv
// Shared types and defaults for the PCI bus arbiter.
package pci_arb_pkg;

   typedef enum logic [2:0] {IDLE, GRANT, BUSY, DEAD, PARK} arb_state_t;

   localparam int DEF_TIMEOUT_CYCLES = 16;
   localparam int TIMER_W            = 5;

endpackage

// File: rtl/pci_arb_rr_pick.sv
// Combinational round-robin picker: first active-low request above last_owner,
// wrapping modulo N.
module pci_arb_rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_n,
   input  logic [W-1:0] last_owner,
   output logic [W-1:0] winner,
   output logic         any_req
);

   int         idx;
   logic [W-1:0] idx_w;

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      winner  = last_owner;
      any_req = 1'b0;
      idx     = 0;
      idx_w   = '0;
      for (int i = N; i >= 1; i--) begin
         idx   = (int'(last_owner) + i) % N;
         idx_w = W'(idx);
         if (!req_n[idx_w]) begin
            winner  = idx_w;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI arbiter: round-robin GNT_ with dead cycle between grants and
// FRAME_ timeout. Bus parking is compiled in with PCI_ARB_PARK_EN.
module pci_arbiter
   import pci_arb_pkg::*;
#(
   parameter int N_MASTERS      = 4,
   parameter int PARK_MASTER    = 0,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_MASTERS-1:0]         REQ_,
   input  logic                         FRAME_,
   input  logic                         IRDY_,
   output logic [N_MASTERS-1:0]         GNT_,
   output logic [$clog2(N_MASTERS)-1:0] owner,
   output logic                         owner_vld,
   output logic                         timeout
);

   localparam int OW = $clog2(N_MASTERS);
   localparam logic [OW-1:0]      PARK_IDX = OW'(PARK_MASTER);
   localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   arb_state_t           state, state_nxt;
   logic [OW-1:0]        owner_r, owner_nxt;
   logic [OW-1:0]        last_owner, last_nxt;
   logic [TIMER_W-1:0]   timer, timer_nxt;
   logic                 to_flag, to_nxt;
   logic [OW-1:0]        winner;
   logic                 any_req;
   logic                 bus_idle, other_req;
   logic [N_MASTERS-1:0] own_1h, gnt_nxt;
   logic                 vld_nxt;

   pci_arb_rr_pick #(.N(N_MASTERS), .W(OW)) u_pick (
      .req_n      (REQ_),
      .last_owner (last_owner),
      .winner     (winner),
      .any_req    (any_req)
   );

   // X/Z on FRAME_/IRDY_ evaluates false in the conditions below: not idle.
   assign bus_idle = FRAME_ & IRDY_;

   always_comb begin
      own_1h          = '0;
      own_1h[owner_r] = 1'b1;
      other_req       = |(~REQ_ & ~own_1h);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         owner_r    <= '0;
         last_owner <= OW'(N_MASTERS - 1);
         timer      <= '0;
         to_flag    <= 1'b0;
      end else begin
         state      <= state_nxt;
         owner_r    <= owner_nxt;
         last_owner <= last_nxt;
         timer      <= timer_nxt;
         to_flag    <= to_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner_r;
      last_nxt  = last_owner;
      timer_nxt = '0;
      to_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = GRANT;
               owner_nxt = winner;
            end
`ifdef PCI_ARB_PARK_EN
            else begin
               state_nxt = PARK;
               owner_nxt = PARK_IDX;
            end
`endif
         end
         GRANT: begin
            timer_nxt = timer;
            if (!FRAME_) begin
               state_nxt = BUSY;
               last_nxt  = owner_r;
               timer_nxt = '0;
            end else if (REQ_[owner_r]) begin
               state_nxt = DEAD;
            end else if (bus_idle) begin
               // Offender drops to lowest priority for the next pick.
               if (timer >= TMO_LAST) begin
                  state_nxt = DEAD;
                  to_nxt    = 1'b1;
                  last_nxt  = owner_r;
               end else if (timer != '1) begin
                  timer_nxt = timer + 1'b1;
               end
            end
         end
         BUSY: begin
            if (bus_idle) state_nxt = DEAD;
         end
         DEAD: state_nxt = IDLE;
`ifdef PCI_ARB_PARK_EN
         PARK: begin
            if (!FRAME_) begin
               state_nxt = BUSY;
               last_nxt  = owner_r;
            end else if (other_req) begin
               state_nxt = DEAD;
            end else if (!REQ_[owner_r]) begin
               state_nxt = GRANT;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Pins are a registered decode of the current state, so they trail the FSM
   // by one cycle; preemption in BUSY releases GNT_ while ownership stays.
   always_comb begin
      gnt_nxt = '1;
      vld_nxt = 1'b0;
      case (state)
         GRANT: begin
            gnt_nxt[owner_r] = 1'b0;
            vld_nxt          = 1'b1;
         end
         BUSY: begin
            if (!other_req) gnt_nxt[owner_r] = 1'b0;
            vld_nxt = 1'b1;
         end
         PARK: begin
            gnt_nxt[PARK_IDX] = 1'b0;
            vld_nxt           = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         GNT_      <= '1;
         owner     <= '0;
         owner_vld <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         GNT_      <= gnt_nxt;
         owner     <= owner_r;
         owner_vld <= vld_nxt;
         timeout   <= to_flag;
      end
   end

endmodule

// File: tb/tb_pci_arbiter.sv
// Scoreboard bench for pci_arbiter: expected grant order queued with stimulus,
// checked when a new GNT_ appears. Park scenario runs with PCI_ARB_PARK_EN.
module tb_pci_arbiter;

   localparam int NM = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [NM-1:0] REQ_;
   logic          FRAME_, IRDY_;
   logic [NM-1:0] GNT_;
   logic [1:0]    owner;
   logic          owner_vld, timeout;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   logic [NM-1:0] prev_gnt = '1;

   pci_arbiter #(.N_MASTERS(NM), .PARK_MASTER(3), .TIMEOUT_CYCLES(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .REQ_      (REQ_),
      .FRAME_    (FRAME_),
      .IRDY_     (IRDY_),
      .GNT_      (GNT_),
      .owner     (owner),
      .owner_vld (owner_vld),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   function automatic int gidx(input logic [NM-1:0] g);
      int r = -1;
      for (int i = NM - 1; i >= 0; i--) if (g[i] === 1'b0) r = i;
      return r;
   endfunction

   // One clock; sample on negedge, run the grant monitor, return for driving.
   task automatic cyc();
      int e;
      @(negedge clk);
      checks++;
      if ($countones(~GNT_) > 1) begin
         errors++;
         $display("FAIL onehot: GNT_=%b, want at most one low", GNT_);
      end
      if (prev_gnt == '1 && GNT_ != '1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant: GNT_=%b, want no grant", GNT_);
         end else begin
            e = exp_q.pop_front();
            if (gidx(GNT_) != e || int'(owner) != e) begin
               errors++;
               $display("FAIL grant_order: GNT_=%b owner=%0d, want master %0d", GNT_, owner, e);
            end
         end
      end else if (prev_gnt != '1 && GNT_ != '1) begin
         checks++;
         if (GNT_ !== prev_gnt) begin
            errors++;
            $display("FAIL dead_cycle: GNT_ %b -> %b, want an all-high cycle between", prev_gnt, GNT_);
         end
      end
      prev_gnt = GNT_;
   endtask

   task automatic wait_grant();
      int n = 0;
      while (GNT_ == '1 && n < 40) begin
         cyc();
         n++;
      end
      checks++;
      if (GNT_ == '1) begin
         errors++;
         $display("FAIL wait_grant: GNT_=%b after %0d cycles, want a grant", GNT_, n);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; REQ_ = '1; FRAME_ = 1'b1; IRDY_ = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
   endtask

   task automatic run_txn();
      FRAME_ = 1'b0; IRDY_ = 1'b0;
      cyc(); cyc();
      FRAME_ = 1'b1;
      cyc();
      IRDY_ = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      reset = 1'b1; REQ_ = '1; FRAME_ = 1'b1; IRDY_ = 1'b1;
      cyc(); cyc();
      checks++;
      if (GNT_ !== 4'b1111 || owner !== 2'd0 || owner_vld !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset: GNT_=%b owner=%0d vld=%b to=%b, want 1111 0 0 0", GNT_, owner, owner_vld, timeout);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      REQ_ = 4'b1110; exp_q.push_back(0);
      cyc();
      checks++;
      if (GNT_ !== 4'b1111) begin errors++; $display("FAIL basic_lat1: GNT_=%b, want 1111", GNT_); end
      cyc();
      checks++;
      if (GNT_ !== 4'b1110 || owner !== 2'd0 || owner_vld !== 1'b1) begin
         errors++;
         $display("FAIL basic_grant: GNT_=%b owner=%0d vld=%b, want 1110 0 1", GNT_, owner, owner_vld);
      end
      FRAME_ = 1'b0;
      cyc();
      FRAME_ = 1'b1; IRDY_ = 1'b0; REQ_ = 4'b1111;
      cyc();
      checks++;
      if (GNT_ !== 4'b1110) begin errors++; $display("FAIL basic_busy: GNT_=%b, want 1110", GNT_); end
      IRDY_ = 1'b1;
      cyc(); cyc();
      checks++;
      if (GNT_ !== 4'b1111 || owner_vld !== 1'b0) begin
         errors++;
         $display("FAIL basic_dead: GNT_=%b vld=%b, want 1111 0", GNT_, owner_vld);
      end
      cyc();
      checks++;
      if (GNT_ !== 4'b1111) begin errors++; $display("FAIL basic_idle: GNT_=%b, want 1111", GNT_); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      REQ_ = 4'b0000;
      foreach (exp_q[i]) exp_q.delete(i);
      for (int k = 0; k < 5; k++) exp_q.push_back(k % NM);
      for (int k = 0; k < 5; k++) begin
         wait_grant();
         if (k == 4) REQ_ = 4'b1111;
         run_txn();
      end
      repeat (4) cyc();
   endtask

   task automatic test_timeout();
      do_reset();
      REQ_ = 4'b1101; exp_q.push_back(1);
      wait_grant();
      REQ_ = 4'b0000;
      for (int i = 1; i < 16; i++) begin
         cyc();
         checks++;
         if (GNT_ !== 4'b1101 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_hold[%0d]: GNT_=%b to=%b, want 1101 0", i, GNT_, timeout);
         end
      end
      cyc();
      checks++;
      if (GNT_ !== 4'b1111 || timeout !== 1'b1) begin
         errors++;
         $display("FAIL tmo_pulse: GNT_=%b to=%b, want 1111 1", GNT_, timeout);
      end
      exp_q.push_back(2);
      cyc();
      checks++;
      if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_width: to=%b, want 0", timeout); end
      wait_grant();
      REQ_ = 4'b1111;
      repeat (4) cyc();
   endtask

   task automatic test_preempt();
      do_reset();
      REQ_ = 4'b1110; exp_q.push_back(0);
      wait_grant();
      FRAME_ = 1'b0;
      cyc();
      REQ_ = 4'b1010;
      cyc();
      checks++;
      if (GNT_ !== 4'b1111 || owner !== 2'd0 || owner_vld !== 1'b1) begin
         errors++;
         $display("FAIL preempt: GNT_=%b owner=%0d vld=%b, want 1111 0 1", GNT_, owner, owner_vld);
      end
      cyc();
      FRAME_ = 1'b1; IRDY_ = 1'b1; REQ_ = 4'b1011; exp_q.push_back(2);
      cyc(); cyc();
      checks++;
      if (owner_vld !== 1'b0) begin errors++; $display("FAIL preempt_dead: vld=%b, want 0", owner_vld); end
      wait_grant();
      checks++;
      if (GNT_ !== 4'b1011) begin errors++; $display("FAIL preempt_next: GNT_=%b, want 1011", GNT_); end
   endtask

   task automatic test_reset_mid();
      FRAME_ = 1'b0;
      cyc(); cyc();
      reset = 1'b1;
      cyc();
      checks++;
      if (GNT_ !== 4'b1111 || owner !== 2'd0 || owner_vld !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: GNT_=%b owner=%0d vld=%b to=%b, want 1111 0 0 0", GNT_, owner, owner_vld, timeout);
      end
      reset = 1'b0; FRAME_ = 1'b1; REQ_ = 4'b1111;
   endtask

   task automatic test_no_park();
      REQ_ = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++;
         if (GNT_ !== 4'b1111 || owner_vld !== 1'b0) begin
            errors++;
            $display("FAIL no_park[%0d]: GNT_=%b vld=%b, want 1111 0", i, GNT_, owner_vld);
         end
      end
   endtask

   task automatic test_park();
      exp_q.push_back(3);
      REQ_ = 4'b1111;
      wait_grant();
      checks++;
      if (GNT_ !== 4'b0111 || owner !== 2'd3 || owner_vld !== 1'b1) begin
         errors++;
         $display("FAIL park: GNT_=%b owner=%0d vld=%b, want 0111 3 1", GNT_, owner, owner_vld);
      end
      REQ_ = 4'b1101; exp_q.push_back(1);
      for (int n = 0; n < 10 && GNT_ != '1; n++) cyc();
      wait_grant();
      checks++;
      if (GNT_ !== 4'b1101) begin errors++; $display("FAIL park_switch: GNT_=%b, want 1101", GNT_); end
   endtask

   initial begin
      test_reset();
`ifdef PCI_ARB_PARK_EN
      test_park();
`else
      test_basic();
      test_back_to_back();
      test_timeout();
      test_preempt();
      test_reset_mid();
      test_no_park();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: %0d grants outstanding, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
